v_dmem_resp: RTL and testbench

//  Memory-side responder for the vector coprocessor's 4-lane data port. It sits between the

---
 rtl/v_pkg.sv | 14 +
 rtl/v_dmem_bank.sv | 24 ++
 rtl/v_dmem_resp.sv | 178 +++++++++++++++++
 tb/tb_v_dmem_resp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared types and helpers for the vector coprocessor data-memory responder.
package v_pkg;

  typedef enum logic [1:0] {DR_IDLE, DR_ISSUE, DR_DRAIN} dmem_state_t;

  localparam int NUM_VLANES = 4;
  localparam int NUM_BANKS  = 4;

  // Words are interleaved across banks on the two low address bits.
  function automatic logic [1:0] bank_of(input logic [31:0] addr);
    return addr[1:0];
  endfunction

endpackage

// File: rtl/v_dmem_bank.sv
// Single-port synchronous SRAM bank: one access per cycle, registered read data.
module v_dmem_bank #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 1024,
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end

endmodule

// File: rtl/v_dmem_resp.sv
// Memory-side responder: accepts one 4-lane vector request, serialises bank
// conflicts across four interleaved banks and returns load data with rsp_valid.
module v_dmem_resp
  import v_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int ROWS   = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  input  logic              is_vstype,
  input  logic [3:0]        lane_en,
  input  logic [ADDR_W-1:0] data_addr0,
  input  logic [ADDR_W-1:0] data_addr1,
  input  logic [ADDR_W-1:0] data_addr2,
  input  logic [ADDR_W-1:0] data_addr3,
  input  logic [DATA_W-1:0] v_store_data_0,
  input  logic [DATA_W-1:0] v_store_data_1,
  input  logic [DATA_W-1:0] v_store_data_2,
  input  logic [DATA_W-1:0] v_store_data_3,
  output logic [DATA_W-1:0] v_load_data_0,
  output logic [DATA_W-1:0] v_load_data_1,
  output logic [DATA_W-1:0] v_load_data_2,
  output logic [DATA_W-1:0] v_load_data_3,
  output logic              busy,
  output logic              rsp_valid
);

  localparam int ROW_W = $clog2(ROWS);

  logic [ADDR_W-1:0] addr_in   [NUM_VLANES];
  logic [DATA_W-1:0] wdata_in  [NUM_VLANES];
  logic [ADDR_W-1:0] addr_reg  [NUM_VLANES];
  logic [DATA_W-1:0] wdata_reg [NUM_VLANES];
  logic [DATA_W-1:0] ld_reg    [NUM_VLANES];
  logic [1:0]        lane_bank [NUM_VLANES];
  logic [ROW_W-1:0]  lane_row  [NUM_VLANES];

  dmem_state_t       state_reg;
  logic [3:0]        pending_reg;
  logic              is_store_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic [3:0]        grant;
  logic [3:0]        pending_next;

  logic [NUM_BANKS-1:0] bank_en;
  logic [1:0]           bank_sel      [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata    [NUM_BANKS];
  logic [NUM_BANKS-1:0] tag_valid_reg;
  logic [1:0]           tag_lane_reg  [NUM_BANKS];

  assign addr_in[0]  = data_addr0;
  assign addr_in[1]  = data_addr1;
  assign addr_in[2]  = data_addr2;
  assign addr_in[3]  = data_addr3;
  assign wdata_in[0] = v_store_data_0;
  assign wdata_in[1] = v_store_data_1;
  assign wdata_in[2] = v_store_data_2;
  assign wdata_in[3] = v_store_data_3;

  assign v_load_data_0 = ld_reg[0];
  assign v_load_data_1 = ld_reg[1];
  assign v_load_data_2 = ld_reg[2];
  assign v_load_data_3 = ld_reg[3];
  assign busy          = busy_reg;
  assign rsp_valid     = rsp_valid_reg;

  // Row index wraps modulo ROWS rather than flagging out-of-range addresses.
  generate
    for (genvar gi = 0; gi < NUM_VLANES; gi++) begin : g_lane
      logic [31:0] row_full;
      assign row_full      = 32'(addr_reg[gi][ADDR_W-1:2]);
      assign lane_bank[gi] = bank_of(32'(addr_reg[gi]));
      assign lane_row[gi]  = ROW_W'(row_full % 32'(ROWS));
    end
  endgenerate

  // Fixed priority: a lane wins only if no lower-index pending lane shares its bank.
  always_comb begin
    grant = '0;
    for (int l = 0; l < NUM_VLANES; l++) begin
      grant[l] = pending_reg[l] && (state_reg == DR_ISSUE);
      for (int j = 0; j < l; j++) begin
        if (pending_reg[j] && (lane_bank[j] == lane_bank[l])) grant[l] = 1'b0;
      end
    end
  end

  always_comb begin
    bank_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = 2'd0;
      for (int l = 0; l < NUM_VLANES; l++) begin
        if (grant[l] && (lane_bank[l] == 2'(b))) begin
          bank_en[b]  = 1'b1;
          bank_sel[b] = 2'(l);
        end
      end
    end
  end

  assign pending_next = pending_reg & ~grant;

  // Accesses are suppressed on a reset edge so an aborted request commits nothing further.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      v_dmem_bank #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
      ) u_bank (
        .clk   (clk),
        .en    (bank_en[gi] & ~nrst),
        .we    (is_store_reg),
        .row   (lane_row[bank_sel[gi]]),
        .wdata (wdata_reg[bank_sel[gi]]),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Each bank remembers which lane it served so next-edge read data reaches the right lane.
  always_ff @(posedge clk) begin
    if (nrst) begin
      tag_valid_reg <= '0;
      for (int b = 0; b < NUM_BANKS; b++) tag_lane_reg[b] <= 2'd0;
      for (int l = 0; l < NUM_VLANES; l++) ld_reg[l] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        tag_valid_reg[b] <= bank_en[b] & ~is_store_reg;
        tag_lane_reg[b]  <= bank_sel[b];
        if (tag_valid_reg[b]) ld_reg[tag_lane_reg[b]] <= bank_rdata[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_reg     <= DR_IDLE;
      pending_reg   <= '0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        DR_IDLE: begin
          if (req_valid) begin
            for (int l = 0; l < NUM_VLANES; l++) begin
              addr_reg[l]  <= addr_in[l];
              wdata_reg[l] <= wdata_in[l];
            end
            is_store_reg <= is_vstype;
            pending_reg  <= lane_en;
            if (lane_en == 4'd0) begin
              rsp_valid_reg <= 1'b1;
            end else begin
              state_reg <= DR_ISSUE;
              busy_reg  <= 1'b1;
            end
          end
        end
        DR_ISSUE: begin
          pending_reg <= pending_next;
          if (pending_next == 4'd0) state_reg <= DR_DRAIN;
        end
        DR_DRAIN: begin
          state_reg     <= DR_IDLE;
          busy_reg      <= 1'b0;
          rsp_valid_reg <= 1'b1;
        end
        default: state_reg <= DR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_dmem_resp.sv
// Randomised and directed bench for v_dmem_resp against a word-array memory model.
module tb_v_dmem_resp;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              nrst;
  logic              req_valid;
  logic              is_vstype;
  logic [3:0]        lane_en;
  logic [ADDR_W-1:0] data_addr0, data_addr1, data_addr2, data_addr3;
  logic [DATA_W-1:0] v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3;
  logic [DATA_W-1:0] v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3;
  logic              busy;
  logic              rsp_valid;

  always #5 clk = ~clk;

  v_dmem_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROWS(1024)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .req_valid      (req_valid),
    .is_vstype      (is_vstype),
    .lane_en        (lane_en),
    .data_addr0     (data_addr0),
    .data_addr1     (data_addr1),
    .data_addr2     (data_addr2),
    .data_addr3     (data_addr3),
    .v_store_data_0 (v_store_data_0),
    .v_store_data_1 (v_store_data_1),
    .v_store_data_2 (v_store_data_2),
    .v_store_data_3 (v_store_data_3),
    .v_load_data_0  (v_load_data_0),
    .v_load_data_1  (v_load_data_1),
    .v_load_data_2  (v_load_data_2),
    .v_load_data_3  (v_load_data_3),
    .busy           (busy),
    .rsp_valid      (rsp_valid)
  );

  typedef struct packed {
    logic [31:0]       lat;
    logic [3:0][31:0]  d;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      mem_m [0:4095];
  logic [3:0][31:0] ld_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outcome: stores land in lane order, loads read the pre-request memory,
  // and latency follows from the busiest bank's lane count.
  function automatic exp_t model(input logic st, input logic [3:0] en,
                                 input logic [3:0][11:0] a, input logic [3:0][31:0] d);
    exp_t e;
    int   cnt [4];
    int   rounds = 0;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    for (int l = 0; l < 4; l++) if (en[l]) cnt[a[l] % 4]++;
    for (int b = 0; b < 4; b++) if (cnt[b] > rounds) rounds = cnt[b];
    if (st) begin
      for (int l = 0; l < 4; l++) if (en[l]) mem_m[a[l]] = d[l];
    end else begin
      for (int l = 0; l < 4; l++) if (en[l]) ld_m[l] = mem_m[a[l]];
    end
    e.lat = (rounds == 0) ? 32'd1 : 32'(rounds + 2);
    e.d   = ld_m;
    return e;
  endfunction

  task automatic apply(input logic st, input logic [3:0] en,
                       input logic [3:0][11:0] a, input logic [3:0][31:0] d);
    is_vstype = st;
    lane_en   = en;
    data_addr0 = a[0]; data_addr1 = a[1]; data_addr2 = a[2]; data_addr3 = a[3];
    v_store_data_0 = d[0]; v_store_data_1 = d[1];
    v_store_data_2 = d[2]; v_store_data_3 = d[3];
  endtask

  // Called just after the accepting edge; counts negedges until rsp_valid.
  task automatic wait_rsp(input exp_t e, input string tag);
    int n    = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      n = i;
      if (i == 1 && e.lat > 1) check_eq({tag, " busy"}, 32'(busy), 32'd1);
      if (rsp_valid) seen = 1'b1;
    end
    check_eq({tag, " lat"}, seen ? 32'(n) : 32'd0, e.lat);
    check_eq({tag, " busy_rsp"}, 32'(busy), 32'd0);
    check_eq({tag, " ld0"}, v_load_data_0, e.d[0]);
    check_eq({tag, " ld1"}, v_load_data_1, e.d[1]);
    check_eq({tag, " ld2"}, v_load_data_2, e.d[2]);
    check_eq({tag, " ld3"}, v_load_data_3, e.d[3]);
    $display("txn %s lat=%0d ld=%h %h %h %h", tag, n,
             v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3);
  endtask

  task automatic send(input logic st, input logic [3:0] en, input logic [3:0][11:0] a,
                      input logic [3:0][31:0] d, input string tag);
    exp_t e;
    apply(st, en, a, d);
    req_valid = 1'b1;
    e = model(st, en, a, d);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(e, tag);
    @(negedge clk);
    check_eq({tag, " pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0][11:0] a;
    logic [3:0][31:0] d;
    logic [3:0][11:0] a2;
    exp_t             ea, eb;
    int               extra;

    nrst = 1'b1;
    req_valid = 1'b0;
    ld_m = '0;
    apply(1'b0, 4'd0, '0, '0);
    repeat (3) @(negedge clk);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst ld0", v_load_data_0, 32'd0);
    check_eq("rst ld3", v_load_data_3, 32'd0);
    nrst = 1'b0;
    @(negedge clk);

    // Fill addresses 0..127 so every later load reads known data.
    for (int k = 0; k < 32; k++) begin
      for (int l = 0; l < 4; l++) begin
        a[l] = 12'(4 * k + l);
        d[l] = $urandom;
      end
      send(1'b1, 4'hF, a, d, "init");
    end

    // Conflict-free store then load of 0..3.
    for (int l = 0; l < 4; l++) begin a[l] = 12'(l); d[l] = 32'hA0 + 32'(l); end
    send(1'b1, 4'hF, a, d, "t1_st");
    send(1'b0, 4'hF, a, d, "t1_ld");

    // All lanes on bank 0.
    for (int l = 0; l < 4; l++) a[l] = 12'(4 * (l + 1));
    send(1'b0, 4'hF, a, d, "t2_ld");

    // Same address on every lane.
    for (int l = 0; l < 4; l++) begin a[l] = 12'd5; d[l] = 32'(11 * (l + 1)); end
    send(1'b1, 4'hF, a, d, "t3_st");
    send(1'b0, 4'hF, a, d, "t3_ld");

    // Partial and empty lane masks.
    for (int l = 0; l < 4; l++) a[l] = 12'(l);
    send(1'b0, 4'b0101, a, d, "t4_ld");
    send(1'b0, 4'b0000, a, d, "t4_nil");

    // Reset during a 4-way conflicting store: only lanes 0 and 1 commit.
    for (int l = 0; l < 4; l++) begin a[l] = 12'(64 + 4 * l); d[l] = $urandom; end
    apply(1'b1, 4'hF, a, d);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1 nrst = 1'b0;
    mem_m[a[0]] = d[0];
    mem_m[a[1]] = d[1];
    ld_m = '0;
    @(negedge clk);
    check_eq("t5 busy", 32'(busy), 32'd0);
    check_eq("t5 ld0", v_load_data_0, 32'd0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check_eq("t5 rsp", 32'(extra), 32'd0);
    send(1'b0, 4'hF, a, d, "t5_ld");

    // Back-to-back with req_valid held: store then load of the same words.
    for (int l = 0; l < 4; l++) begin a[l] = 12'(100 + 5 * l); d[l] = $urandom; end
    apply(1'b1, 4'hF, a, d);
    req_valid = 1'b1;
    ea = model(1'b1, 4'hF, a, d);
    @(posedge clk);
    #1;
    apply(1'b0, 4'hF, a, d);
    eb = model(1'b0, 4'hF, a, d);
    wait_rsp(ea, "t6_st");
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(eb, "t6_ld");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check_eq("t6 extra", 32'(extra), 32'd0);

    // Random mix with deliberate bank and address collisions.
    for (int t = 0; t < 60; t++) begin
      for (int l = 0; l < 4; l++) begin
        a2[l] = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 7) * 4)
                                            : 12'($urandom_range(0, 127));
        if (l > 0 && $urandom_range(0, 4) == 0) a2[l] = a2[0];
        d[l] = $urandom;
      end
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a2, d, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
